fir_axis_out_buf: RTL and testbench
===================================

Name: fir_axis_out_buf

Overview:
Downstream stage of the FIR engine. Consumes the FIR AXI-Stream master output (sm_*), buffers it in a small register FIFO, and re-presents it as an AXI-Stream master toward the DMA/consumer. It also checks frame length against the configured data_length and reports tlast framing errors and frame completion.

Parameters:
pDATA_WIDTH, 32, stream data width
pDEPTH, 8, FIFO depth in beats; power of 2, minimum 2
pCNT_WIDTH, 32, width of data_length and the beat counter

Ports:
axis_clk  input  1  clock, all logic rising-edge
axis_rst_n  input  1  asynchronous active-low reset
s_tvalid  input  1  beat valid from FIR (sm_tvalid)
s_tdata  input  pDATA_WIDTH  beat data from FIR (sm_tdata)
s_tlast  input  1  last beat of frame from FIR (sm_tlast)
s_tready  output  1  ready to FIR (drives sm_tready)
m_tvalid  output  1  beat valid to consumer
m_tdata  output  pDATA_WIDTH  beat data to consumer
m_tlast  output  1  tlast to consumer, carried through FIFO with its beat
m_tready  input  1  consumer ready
data_length  input  pCNT_WIDTH  expected beats per frame (AXI-Lite reg 0x10); 0 disables length checks
clr  input  1  synchronous clear of counter and error flags
level  output  $clog2(pDEPTH)+1  current FIFO occupancy
err_early  output  1  sticky: tlast seen before data_length beats
err_missing  output  1  sticky: data_length-th beat arrived without tlast
frame_done  output  1  one-cycle pulse when a tlast beat is accepted by consumer

Behaviour:
- Reset (async assert, sync-release usage): FIFO empty, level=0, s_tready=1, m_tvalid=0, m_tdata=0, m_tlast=0, err_early=0, err_missing=0, frame_done=0, beat counter=0.
- Push: s_tvalid & s_tready. Pop: m_tvalid & m_tready. s_tready = (level < pDEPTH), registered-equivalent, no combinational path from m_tready.
- Full: s_tready=0, even if a pop happens that cycle; ready reasserts the cycle after the pop.
- Empty + push: m_tvalid rises the next cycle (latency 1), m_tdata/m_tlast equal the pushed beat. No same-cycle bypass.
- Simultaneous push and pop when 0 < level < pDEPTH: level unchanged, order preserved.
- m_tdata/m_tlast held stable while m_tvalid & !m_tready (AXIS rule). m_tvalid never drops without a pop.
- Pointers: read/write pointers of $clog2(pDEPTH) bits wrap naturally. level counts 0..pDEPTH.
- Frame checking is done on push side. On each push with data_length != 0:
  - s_tlast & cnt != data_length-1: set err_early, cnt <= 0.
  - !s_tlast & cnt == data_length-1: set err_missing, cnt <= 0.
  - s_tlast & cnt == data_length-1: good frame, cnt <= 0.
  - otherwise cnt <= cnt+1.
- data_length==0: no flags set; cnt resets only on tlast.
- Errors are sticky until clr or reset. clr: cnt <= 0, flags cleared. FIFO contents are kept. clr has priority over flag set in the same cycle.
- frame_done: registered, high for exactly one cycle after a pop with m_tlast=1.
- data_length is sampled each push. Changing it mid-frame takes effect on the next push.
- Reset mid-frame: FIFO contents are lost and outputs return to reset values immediately.

Test Plan:
- Length-8 frame, values 1..8, tlast on 8th, data_length=8, m_tready=1 -> outputs 1..8 in order with tlast on 8, one cycle latency, frame_done pulses once, no error flags.
- m_tready=0, push 9 beats -> level reaches 8, s_tready=0 after 8th accept, 9th held. Raise m_tready -> 9th accepted the cycle after the first pop, all 9 beats in order, m_tdata stable while stalled.
- Continuous push/pop at level=4 for 600 beats (FIR test length) with data_length=600, tlast on beat 599 -> level stays 4, data matches, wrap-around clean, no errors.
- data_length=5, tlast on 3rd beat -> err_early=1 after that push. Next frame has 5 beats with no tlast -> err_missing=1. Pulse clr -> both 0.
- data_length=0, random tlast positions -> no error flags, frame_done matches each tlast.
- Assert axis_rst_n=0 with level=5 mid-frame -> m_tvalid=0, level=0, s_tready=1 without waiting for a clock edge; the first post-reset frame passes with no errors.

Source files
------------

// File: rtl/fir_axis_out_buf.sv
`default_nettype none
// ============================================================================
// Module   : fir_axis_out_buf
// Purpose  : Register-FIFO output buffer for the FIR AXI-Stream master, with
//            push-side frame length checking and frame completion pulse.
// Revision : 1.0 - initial release
// ============================================================================
module fir_axis_out_buf #(
   parameter int pDATA_WIDTH = 32,
   parameter int pDEPTH      = 8,
   parameter int pCNT_WIDTH  = 32
) (
   input  logic                       axis_clk,
   input  logic                       axis_rst_n,
   input  logic                       s_tvalid,
   input  logic [pDATA_WIDTH-1:0]     s_tdata,
   input  logic                       s_tlast,
   output logic                       s_tready,
   output logic                       m_tvalid,
   output logic [pDATA_WIDTH-1:0]     m_tdata,
   output logic                       m_tlast,
   input  logic                       m_tready,
   input  logic [pCNT_WIDTH-1:0]      data_length,
   input  logic                       clr,
   output logic [$clog2(pDEPTH):0]    level,
   output logic                       err_early,
   output logic                       err_missing,
   output logic                       frame_done
);

   localparam int c_AW = $clog2(pDEPTH);
   localparam int c_LW = c_AW + 1;

   // Each entry carries tlast in its MSB alongside the data beat.
   logic [pDATA_WIDTH:0]    r_mem [pDEPTH];
   logic [c_AW-1:0]         r_wr_ptr;
   logic [c_AW-1:0]         r_rd_ptr;
   logic [c_LW-1:0]         r_level;
   logic [pCNT_WIDTH-1:0]   r_cnt;
   logic                    r_err_early;
   logic                    r_err_missing;
   logic                    r_frame_done;

   logic                    w_push;
   logic                    w_pop;
   logic [pDATA_WIDTH:0]    w_head;
   logic [pCNT_WIDTH-1:0]   w_last_idx;
   logic [pCNT_WIDTH-1:0]   w_cnt_nxt;
   logic                    w_set_early;
   logic                    w_set_missing;

   // Ready depends only on registered occupancy, never on m_tready.
   assign s_tready = (r_level != c_LW'(pDEPTH));
   assign m_tvalid = (r_level != '0);
   assign w_push   = s_tvalid & s_tready;
   assign w_pop    = m_tvalid & m_tready;
   assign w_head   = r_mem[r_rd_ptr];
   assign m_tdata  = m_tvalid ? w_head[pDATA_WIDTH-1:0] : '0;
   assign m_tlast  = m_tvalid & w_head[pDATA_WIDTH];

   assign level       = r_level;
   assign err_early   = r_err_early;
   assign err_missing = r_err_missing;
   assign frame_done  = r_frame_done;

   always_ff @(posedge axis_clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {s_tlast, s_tdata};
      end
   end

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_level      <= '0;
         r_frame_done <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + c_LW'(1);
            2'b01:   r_level <= r_level - c_LW'(1);
            default: r_level <= r_level;
         endcase
         r_frame_done <= w_pop & m_tlast;
      end
   end

   assign w_last_idx = data_length - pCNT_WIDTH'(1);

   always_comb begin
      w_cnt_nxt     = r_cnt;
      w_set_early   = 1'b0;
      w_set_missing = 1'b0;
      if (w_push) begin
         if (data_length == '0) begin
            w_cnt_nxt = s_tlast ? '0 : r_cnt + pCNT_WIDTH'(1);
         end else if (s_tlast && (r_cnt != w_last_idx)) begin
            w_set_early = 1'b1;
            w_cnt_nxt   = '0;
         end else if (!s_tlast && (r_cnt == w_last_idx)) begin
            w_set_missing = 1'b1;
            w_cnt_nxt     = '0;
         end else if (s_tlast) begin
            w_cnt_nxt = '0;
         end else begin
            w_cnt_nxt = r_cnt + pCNT_WIDTH'(1);
         end
      end
   end

   // clr wins over any flag set from a push in the same cycle.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         r_cnt         <= '0;
         r_err_early   <= 1'b0;
         r_err_missing <= 1'b0;
      end else if (clr) begin
         r_cnt         <= '0;
         r_err_early   <= 1'b0;
         r_err_missing <= 1'b0;
      end else begin
         r_cnt <= w_cnt_nxt;
         if (w_set_early) begin
            r_err_early <= 1'b1;
         end
         if (w_set_missing) begin
            r_err_missing <= 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fir_axis_out_buf.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_axis_out_buf
// Purpose  : Directed self-checking bench for fir_axis_out_buf.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_axis_out_buf;

   localparam int c_DW = 32;
   localparam int c_DEPTH = 8;
   localparam int c_CW = 32;

   logic            axis_clk = 1'b0;
   logic            axis_rst_n = 1'b0;
   logic            s_tvalid = 1'b0;
   logic [c_DW-1:0] s_tdata = '0;
   logic            s_tlast = 1'b0;
   logic            s_tready;
   logic            m_tvalid;
   logic [c_DW-1:0] m_tdata;
   logic            m_tlast;
   logic            m_tready = 1'b0;
   logic [c_CW-1:0] data_length = '0;
   logic            clr = 1'b0;
   logic [3:0]      level;
   logic            err_early;
   logic            err_missing;
   logic            frame_done;

   int errors = 0;
   int checks = 0;

   fir_axis_out_buf #(
      .pDATA_WIDTH(c_DW),
      .pDEPTH     (c_DEPTH),
      .pCNT_WIDTH (c_CW)
   ) dut (
      .axis_clk   (axis_clk),
      .axis_rst_n (axis_rst_n),
      .s_tvalid   (s_tvalid),
      .s_tdata    (s_tdata),
      .s_tlast    (s_tlast),
      .s_tready   (s_tready),
      .m_tvalid   (m_tvalid),
      .m_tdata    (m_tdata),
      .m_tlast    (m_tlast),
      .m_tready   (m_tready),
      .data_length(data_length),
      .clr        (clr),
      .level      (level),
      .err_early  (err_early),
      .err_missing(err_missing),
      .frame_done (frame_done)
   );

   always #5 axis_clk = ~axis_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are then observed 1 time unit after the edge.
   task automatic step();
      @(posedge axis_clk);
      #1;
   endtask

   logic [9:0] tl_pat;

   initial begin
      // ---------------- reset state ----------------
      #12;
      chk("rst_level", level, 0);
      chk("rst_s_tready", s_tready, 1);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_m_tdata", m_tdata, 0);
      chk("rst_m_tlast", m_tlast, 0);
      chk("rst_errs", {err_early, err_missing}, 0);
      chk("rst_frame_done", frame_done, 0);
      axis_rst_n = 1'b1;
      step();

      // ---------------- length-8 frame, 1..8 ----------------
      data_length = 8;
      m_tready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         s_tvalid = 1'b1; s_tdata = i; s_tlast = (i == 8);
         step();
         chk("f8_valid", m_tvalid, 1);
         chk("f8_data", m_tdata, i);
         chk("f8_last", m_tlast, (i == 8));
         chk("f8_level", level, 1);
         chk("f8_fd_quiet", frame_done, 0);
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      step();
      chk("f8_fd_pulse", frame_done, 1);
      chk("f8_empty", m_tvalid, 0);
      step();
      chk("f8_fd_once", frame_done, 0);
      chk("f8_errs", {err_early, err_missing}, 0);

      // ---------------- stall: 9 beats into depth 8 ----------------
      data_length = 0;
      m_tready = 1'b0;
      for (int i = 0; i < 8; i++) begin
         s_tvalid = 1'b1; s_tdata = 32'h100 + i;
         step();
      end
      chk("st_level_full", level, 8);
      chk("st_ready_low", s_tready, 0);
      s_tdata = 32'h108;
      step();
      chk("st_level_held", level, 8);
      chk("st_head_stable", m_tdata, 32'h100);
      chk("st_valid_held", m_tvalid, 1);
      m_tready = 1'b1;
      step();
      chk("st_pop_full_level", level, 7);
      chk("st_ready_back", s_tready, 1);
      chk("st_head1", m_tdata, 32'h101);
      step();
      s_tvalid = 1'b0;
      chk("st_push9_level", level, 7);
      for (int k = 2; k <= 8; k++) begin
         chk("st_drain", m_tdata, 32'h100 + k);
         step();
      end
      chk("st_drained", level, 0);
      clr = 1'b1;
      step();
      clr = 1'b0;

      // ---------------- 600 beats at level 4 ----------------
      data_length = 600;
      m_tready = 1'b0;
      for (int j = 0; j < 4; j++) begin
         s_tvalid = 1'b1; s_tdata = 32'hA000_0000 + j; s_tlast = 1'b0;
         step();
      end
      chk("c_level_init", level, 4);
      m_tready = 1'b1;
      for (int j = 4; j < 600; j++) begin
         s_tdata = 32'hA000_0000 + j; s_tlast = (j == 599);
         step();
         chk("c_level", level, 4);
         chk("c_head", m_tdata, 32'hA000_0000 + j - 3);
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      step(); step(); step();
      chk("c_last_head", m_tdata, 32'hA000_0000 + 599);
      chk("c_last_tlast", m_tlast, 1);
      step();
      chk("c_fd", frame_done, 1);
      chk("c_empty", level, 0);
      chk("c_errs", {err_early, err_missing}, 0);

      // ---------------- early / missing tlast, clr ----------------
      data_length = 5;
      for (int i = 1; i <= 3; i++) begin
         s_tvalid = 1'b1; s_tdata = i; s_tlast = (i == 3);
         step();
      end
      chk("e_early", err_early, 1);
      chk("e_no_missing", err_missing, 0);
      for (int i = 1; i <= 5; i++) begin
         s_tdata = 32'h50 + i; s_tlast = 1'b0;
         step();
         if (i == 4) chk("e_missing_pre", err_missing, 0);
      end
      chk("e_missing", err_missing, 1);
      // clr together with a push that would flag early tlast (cnt=0, len=5)
      clr = 1'b1; s_tdata = 32'h60; s_tlast = 1'b1;
      step();
      clr = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
      chk("e_clr_early", err_early, 0);
      chk("e_clr_missing", err_missing, 0);
      step(); step();
      chk("e_drained", level, 0);

      // ---------------- data_length = 0, arbitrary tlast ----------------
      data_length = 0;
      tl_pat = 10'b0100100011;
      for (int i = 0; i < 10; i++) begin
         s_tvalid = 1'b1; s_tdata = 32'h70 + i; s_tlast = tl_pat[i];
         step();
         chk("z_fd", frame_done, (i > 0) ? tl_pat[i-1] : 1'b0);
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      step();
      chk("z_fd_last", frame_done, tl_pat[9]);
      chk("z_errs", {err_early, err_missing}, 0);

      // ---------------- async reset mid-frame ----------------
      data_length = 8;
      m_tready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         s_tvalid = 1'b1; s_tdata = 32'h80 + i;
         step();
      end
      s_tvalid = 1'b0;
      chk("r_level5", level, 5);
      #2 axis_rst_n = 1'b0;
      #1;
      chk("r_async_valid", m_tvalid, 0);
      chk("r_async_level", level, 0);
      chk("r_async_ready", s_tready, 1);
      #1 axis_rst_n = 1'b1;
      data_length = 3;
      m_tready = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         s_tvalid = 1'b1; s_tdata = 32'h90 + i; s_tlast = (i == 3);
         step();
         chk("r_post_data", m_tdata, 32'h90 + i);
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      step();
      chk("r_post_fd", frame_done, 1);
      chk("r_post_errs", {err_early, err_missing}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
